// File: rtl/conv2_layer_ctrl.sv
// conv2_layer_ctrl: sequencer for the Convolution 2 layer.
// Walks 3 kernel pairs x 64 output positions. Each position takes 28 cycles:
// CLEAR, 25 ACCUM cycles, DRAIN and WRITE. Each cycle it issues two weight
// addresses, one feature address and the MAC/write strobes.
// All outputs are registered. They are computed from the next-state values,
// so every output lines up with the state it belongs to.
// Optional feature: define CONV2_ABORT_EN to add the abort input. Abort
// cancels a running layer with no write and no done pulse.
module conv2_layer_ctrl #(
    parameter int IN_DIM     = 12,
    parameter int K_DIM      = 5,
    parameter int OUT_DIM    = IN_DIM - K_DIM + 1,
    parameter int N_PAIRS    = 3,
    parameter int BANK1_BASE = 75
) (
    input  logic       clk,
    input  logic       reset,
`ifdef CONV2_ABORT_EN
    input  logic       abort,
`endif
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [1:0] pair,
    output logic [7:0] w_addr0,
    output logic [7:0] w_addr1,
    output logic [7:0] f_addr,
    output logic       mac_clr,
    output logic       mac_en,
    output logic       wr_en,
    output logic [8:0] out_addr0,
    output logic [8:0] out_addr1
);

    localparam int K_WORDS = K_DIM * K_DIM;
    localparam int N_POS   = OUT_DIM * OUT_DIM;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t     state, state_n;
    logic [4:0] k, k_n;            // linear kernel index 0..24
    logic [2:0] kr, kr_n;          // kernel row of k
    logic [2:0] kc, kc_n;          // kernel column of k
    logic [2:0] ocol, ocol_n;
    logic [2:0] orow, orow_n;
    logic [1:0] pair_q, pair_n;

    logic       last_pos;
    logic       abort_hit;
    logic [7:0] w0_n, w1_n, f_n;
    logic [8:0] o0_n, o1_n;

    assign last_pos = (ocol == 3'(OUT_DIM - 1)) && (orow == 3'(OUT_DIM - 1)) &&
                      (pair_q == 2'(N_PAIRS - 1));

`ifdef CONV2_ABORT_EN
    assign abort_hit = abort && (state != S_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    // State and position counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            k      <= '0;
            kr     <= '0;
            kc     <= '0;
            ocol   <= '0;
            orow   <= '0;
            pair_q <= '0;
        end else begin
            state  <= state_n;
            k      <= k_n;
            kr     <= kr_n;
            kc     <= kc_n;
            ocol   <= ocol_n;
            orow   <= orow_n;
            pair_q <= pair_n;
        end
    end

    // Next-state and counter stepping. Counters are rewound on every path
    // back to IDLE, so a new start always begins at pair 0, position 0.
    always_comb begin
        state_n = state;
        k_n     = k;
        kr_n    = kr;
        kc_n    = kc;
        ocol_n  = ocol;
        orow_n  = orow;
        pair_n  = pair_q;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_CLEAR;
                    k_n     = '0;
                    kr_n    = '0;
                    kc_n    = '0;
                    ocol_n  = '0;
                    orow_n  = '0;
                    pair_n  = '0;
                end
            end
            S_CLEAR: state_n = S_ACCUM;
            S_ACCUM: begin
                if (k == 5'(K_WORDS - 1)) begin
                    // Hold k at its last value so DRAIN keeps the addresses.
                    state_n = S_DRAIN;
                end else begin
                    k_n = k + 5'd1;
                    if (kc == 3'(K_DIM - 1)) begin
                        kc_n = '0;
                        kr_n = kr + 3'd1;
                    end else begin
                        kc_n = kc + 3'd1;
                    end
                end
            end
            S_DRAIN: state_n = S_WRITE;
            S_WRITE: begin
                k_n  = '0;
                kr_n = '0;
                kc_n = '0;
                if (last_pos) begin
                    state_n = S_DONE;
                    ocol_n  = '0;
                    orow_n  = '0;
                    pair_n  = '0;
                end else begin
                    state_n = S_CLEAR;
                    if (ocol == 3'(OUT_DIM - 1)) begin
                        ocol_n = '0;
                        if (orow == 3'(OUT_DIM - 1)) begin
                            orow_n = '0;
                            pair_n = pair_q + 2'd1;
                        end else begin
                            orow_n = orow + 3'd1;
                        end
                    end else begin
                        ocol_n = ocol + 3'd1;
                    end
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (abort_hit) begin
            state_n = S_IDLE;
            k_n     = '0;
            kr_n    = '0;
            kc_n    = '0;
            ocol_n  = '0;
            orow_n  = '0;
            pair_n  = '0;
        end
    end

    // Address arithmetic on the next-state counters (unsigned, never wraps)
    always_comb begin
        w0_n = 8'(pair_n) * 8'(K_WORDS) + 8'(k_n);
        w1_n = w0_n + 8'(BANK1_BASE);
        f_n  = (8'(orow_n) + 8'(kr_n)) * 8'(IN_DIM) + 8'(ocol_n) + 8'(kc_n);
        o0_n = 9'(pair_n) * 9'(2 * N_POS) + 9'(orow_n) * 9'(OUT_DIM) + 9'(ocol_n);
        o1_n = o0_n + 9'(N_POS);
    end

    // Registered outputs. mac_en trails each address by one cycle because
    // the memories have one cycle of read latency. It is therefore off on
    // the first ACCUM cycle and on during DRAIN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            pair      <= '0;
            w_addr0   <= '0;
            w_addr1   <= '0;
            f_addr    <= '0;
            mac_clr   <= 1'b0;
            mac_en    <= 1'b0;
            wr_en     <= 1'b0;
            out_addr0 <= '0;
            out_addr1 <= '0;
        end else begin
            busy    <= (state_n != S_IDLE);
            done    <= (state_n == S_DONE);
            pair    <= pair_n;
            mac_clr <= (state_n == S_CLEAR);
            mac_en  <= ((state_n == S_ACCUM) && (k_n != 5'd0)) || (state_n == S_DRAIN);
            wr_en   <= (state_n == S_WRITE);
            if (state_n == S_IDLE) begin
                w_addr0   <= '0;
                w_addr1   <= '0;
                f_addr    <= '0;
                out_addr0 <= '0;
                out_addr1 <= '0;
            end else begin
                w_addr0   <= w0_n;
                w_addr1   <= w1_n;
                f_addr    <= f_n;
                out_addr0 <= o0_n;
                out_addr1 <= o1_n;
            end
        end
    end

endmodule
